// File: rtl/ptch_integrator.sv
// Pitch integrator: offset-compensates gyro rate and Z accel, integrates rate into pitch
// with complementary-filter pull toward accel pitch, and strobes vld once settled.
// Latency: one clk from smpl_vld to updated ptch/ptch_rt/vld; no backpressure (consumer must keep up).
module ptch_integrator #(
  parameter logic               fast_sim       = 1'b1,
  parameter logic signed [15:0] PTCH_RT_OFFSET = 16'sh0050,
  parameter logic signed [15:0] AZ_OFFSET      = 16'sh00A0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               smpl_vld,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic signed [15:0] AZ,
  output logic               vld,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt
);

  localparam logic [7:0] SETTLE = fast_sim ? 8'd4 : 8'd200;

  localparam logic signed [26:0] INT_MAX = {1'b0, {26{1'b1}}};
  localparam logic signed [26:0] INT_MIN = {1'b1, {26{1'b0}}};

  // Sample phase decoded from the saturating sample counter; only rst leaves RUN.
  typedef enum logic {
    SETTLING = 1'b0,
    RUN      = 1'b1
  } smpl_state_e;

  smpl_state_e smpl_state;

  logic signed [26:0] ptch_int_q, ptch_int_d;
  logic signed [15:0] ptch_rt_q, ptch_rt_d;
  logic        [7:0]  smpl_cnt_q, smpl_cnt_d;
  logic               vld_q, vld_d;

  logic signed [16:0] ptch_rt_comp;
  logic signed [16:0] az_comp;
  logic signed [26:0] acc_prod;
  logic signed [15:0] ptch_acc;
  logic signed [27:0] fusion_offset;
  logic        [27:0] int_sum;
  logic signed [26:0] int_clamped;
  logic signed [15:0] rt_sat;

  // Offset removal, accel pitch, fusion step and saturating accumulate.
  always_comb begin
    ptch_rt_comp  = {ptch_rt_raw[15], ptch_rt_raw} - {PTCH_RT_OFFSET[15], PTCH_RT_OFFSET};
    az_comp       = {AZ[15], AZ} - {AZ_OFFSET[15], AZ_OFFSET};

    // 327/8192 scales compensated accel into pitch units; magnitude stays well inside 27 bits.
    acc_prod      = $signed({{10{az_comp[16]}}, az_comp}) * $signed(27'sd327);
    ptch_acc      = 16'(acc_prod >>> 13);

    // Compare against the pitch currently held, not the one being computed.
    fusion_offset = (ptch_acc > ptch) ? 28'sd1024 : -28'sd1024;

    int_sum       = {ptch_int_q[26], ptch_int_q}
                  - {{11{ptch_rt_comp[16]}}, ptch_rt_comp}
                  + fusion_offset;

    // Top two bits disagreeing means the 28-bit sum left the 27-bit range.
    case (int_sum[27:26])
      2'b01:   int_clamped = INT_MAX;
      2'b10:   int_clamped = INT_MIN;
      default: int_clamped = int_sum[26:0];
    endcase

    if (ptch_rt_comp[16] != ptch_rt_comp[15]) begin
      rt_sat = ptch_rt_comp[16] ? 16'sh8000 : 16'sh7FFF;
    end else begin
      rt_sat = ptch_rt_comp[15:0];
    end
  end

  // Next-state: load on a sample, hold otherwise; vld only on a sample taken in RUN.
  always_comb begin
    ptch_int_d = ptch_int_q;
    ptch_rt_d  = ptch_rt_q;
    smpl_cnt_d = smpl_cnt_q;
    vld_d      = 1'b0;
    smpl_state = (smpl_cnt_q == SETTLE) ? RUN : SETTLING;

    if (smpl_vld) begin
      ptch_int_d = int_clamped;
      ptch_rt_d  = rt_sat;
      vld_d      = (smpl_state == RUN);
      if (smpl_state == SETTLING) begin
        smpl_cnt_d = smpl_cnt_q + 8'd1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptch_int_q <= '0;
      ptch_rt_q  <= '0;
      smpl_cnt_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      ptch_int_q <= ptch_int_d;
      ptch_rt_q  <= ptch_rt_d;
      smpl_cnt_q <= smpl_cnt_d;
      vld_q      <= vld_d;
    end
  end

  assign ptch    = ptch_int_q[26:11];
  assign ptch_rt = ptch_rt_q;
  assign vld     = vld_q;

endmodule

// File: tb/tb_ptch_integrator.sv
// Bench for ptch_integrator with an integer reference model of the pitch filter.
module tb_ptch_integrator;

  logic        clk = 1'b0;
  logic        rst;
  logic        smpl_vld;
  logic [15:0] ptch_rt_raw;
  logic [15:0] AZ;
  logic        vld;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;

  int total = 0;
  int bad   = 0;

  localparam int SETTLE = 4;
  localparam int IMAX   = (1 << 26) - 1;
  localparam int IMIN   = -(1 << 26);

  // Reference model state
  int   m_int;
  int   m_rt;
  int   m_cnt;
  logic m_vld;

  ptch_integrator dut (
    .clk        (clk),
    .rst        (rst),
    .smpl_vld   (smpl_vld),
    .ptch_rt_raw(ptch_rt_raw),
    .AZ         (AZ),
    .vld        (vld),
    .ptch       (ptch),
    .ptch_rt    (ptch_rt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_ptch();
    return 16'(m_int >>> 11);
  endfunction

  function automatic logic [26:0] dut_int();
    return dut.ptch_int_q;
  endfunction

  task automatic model_reset();
    m_int = 0;
    m_rt  = 0;
    m_cnt = 0;
    m_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one sample, update the model, return 1 time unit after the capturing edge.
  task automatic apply_sample(input logic [15:0] raw, input logic [15:0] az);
    int rt_c, az_c, acc, cur, off, s;
    ptch_rt_raw = raw;
    AZ          = az;
    smpl_vld    = 1'b1;
    @(posedge clk);
    rt_c = int'($signed(raw)) - 80;
    az_c = int'($signed(az)) - 160;
    acc  = (az_c * 327) >>> 13;
    cur  = m_int >>> 11;
    off  = (acc > cur) ? 1024 : -1024;
    s    = m_int - rt_c + off;
    if (s > IMAX) s = IMAX;
    if (s < IMIN) s = IMIN;
    m_int = s;
    m_rt  = (rt_c > 32767) ? 32767 : ((rt_c < -32768) ? -32768 : rt_c);
    m_vld = (m_cnt == SETTLE);
    if (m_cnt < SETTLE) m_cnt = m_cnt + 1;
    #1;
    smpl_vld    = 1'b0;
    ptch_rt_raw = 16'($urandom);
    AZ          = 16'($urandom);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ptch !== 16'h0000) begin bad++; $display("FAIL reset_ptch: got %h want 0000", ptch); end
    total++; if (ptch_rt !== 16'h0000) begin bad++; $display("FAIL reset_ptch_rt: got %h want 0000", ptch_rt); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", vld); end
    for (int i = 0; i < 6; i++) apply_sample(16'h0850, 16'h20A0);
    total++; if (vld !== 1'b1) begin bad++; $display("FAIL pre_reset_vld: got %b want 1", vld); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (ptch !== 16'h0000) begin bad++; $display("FAIL async_ptch: got %h want 0000", ptch); end
    total++; if (ptch_rt !== 16'h0000) begin bad++; $display("FAIL async_ptch_rt: got %h want 0000", ptch_rt); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL async_vld: got %b want 0", vld); end
    smpl_vld    = 1'b1;
    ptch_rt_raw = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (ptch !== 16'h0000 || ptch_rt !== 16'h0000 || vld !== 1'b0) begin
        bad++; $display("FAIL hold_in_reset: got ptch=%h rt=%h vld=%b want 0", ptch, ptch_rt, vld);
      end
    end
    smpl_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_settle();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      apply_sample(16'h0050, 16'h00A0);
      total++; if (vld !== (i == 5)) begin bad++; $display("FAIL settle_vld[%0d]: got %b want %b", i, vld, (i == 5)); end
      total++; if (ptch !== ((i % 2) ? 16'hFFFF : 16'h0000)) begin bad++; $display("FAIL settle_ptch[%0d]: got %h want %h", i, ptch, ((i % 2) ? 16'hFFFF : 16'h0000)); end
      total++; if (ptch_rt !== 16'h0000) begin bad++; $display("FAIL settle_rt[%0d]: got %h want 0000", i, ptch_rt); end
    end
    idle_cycle();
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL settle_vld_one_cycle: got %b want 0", vld); end
  endtask

  task automatic test_rate();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply_sample(16'h0850, 16'h00A0);
      total++; if (ptch !== exp_ptch()) begin bad++; $display("FAIL rate_ptch[%0d]: got %h want %h", i, ptch, exp_ptch()); end
      total++; if (ptch_rt !== 16'h0800) begin bad++; $display("FAIL rate_rt[%0d]: got %h want 0800", i, ptch_rt); end
    end
    total++; if (dut_int() !== 27'(m_int)) begin bad++; $display("FAIL rate_int: got %0d want %0d", $signed(dut_int()), m_int); end
  endtask

  task automatic test_fusion();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      apply_sample(16'h0050, 16'h20A0);
      total++; if (ptch !== exp_ptch()) begin bad++; $display("FAIL fusion_ptch[%0d]: got %h want %h", i, ptch, exp_ptch()); end
    end
    total++; if (ptch !== 16'h0032) begin bad++; $display("FAIL fusion_final_ptch: got %h want 0032", ptch); end
    total++; if (dut_int() !== 27'(102400)) begin bad++; $display("FAIL fusion_int: got %0d want 102400", $signed(dut_int())); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 2200; i++) begin
      apply_sample(16'h7FFF, 16'h00A0);
      total++; if (ptch !== exp_ptch()) begin bad++; $display("FAIL satn_ptch[%0d]: got %h want %h", i, ptch, exp_ptch()); end
    end
    total++; if (dut_int() !== 27'(IMIN)) begin bad++; $display("FAIL satn_int: got %0d want %0d", $signed(dut_int()), IMIN); end
    total++; if (ptch !== 16'h8000) begin bad++; $display("FAIL satn_ptch_rail: got %h want 8000", ptch); end
    apply_sample(16'h8000, 16'h00A0);
    total++; if (dut_int() !== 27'(IMIN + 32848 + 1024)) begin bad++; $display("FAIL satn_release: got %0d want %0d", $signed(dut_int()), IMIN + 32848 + 1024); end
    total++; if (ptch_rt !== 16'h8000) begin bad++; $display("FAIL satn_rt_clamp: got %h want 8000", ptch_rt); end
    for (int i = 0; i < 4400; i++) apply_sample(16'h8000, 16'h00A0);
    total++; if (dut_int() !== 27'(IMAX)) begin bad++; $display("FAIL satp_int: got %0d want %0d", $signed(dut_int()), IMAX); end
    total++; if (ptch !== 16'h7FFF) begin bad++; $display("FAIL satp_ptch_rail: got %h want 7fff", ptch); end
    apply_sample(16'h7FFF, 16'h00A0);
    total++; if (dut_int() !== 27'(m_int)) begin bad++; $display("FAIL satp_release: got %0d want %0d", $signed(dut_int()), m_int); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < SETTLE; i++) apply_sample(16'h0050, 16'h00A0);
    for (int i = 0; i < 3; i++) begin
      apply_sample(16'h0150, 16'h10A0);
      total++; if (vld !== 1'b1) begin bad++; $display("FAIL b2b_vld[%0d]: got %b want 1", i, vld); end
      total++; if (ptch !== exp_ptch()) begin bad++; $display("FAIL b2b_ptch[%0d]: got %h want %h", i, ptch, exp_ptch()); end
    end
  endtask

  task automatic test_random();
    logic [15:0] held_ptch, held_rt;
    int gap;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply_sample(16'($urandom), 16'($urandom));
      total++; if (vld !== m_vld) begin bad++; $display("FAIL rnd_vld[%0d]: got %b want %b", i, vld, m_vld); end
      total++; if (ptch !== exp_ptch()) begin bad++; $display("FAIL rnd_ptch[%0d]: got %h want %h", i, ptch, exp_ptch()); end
      total++; if (ptch_rt !== 16'(m_rt)) begin bad++; $display("FAIL rnd_rt[%0d]: got %h want %h", i, ptch_rt, 16'(m_rt)); end
      held_ptch = exp_ptch();
      held_rt   = 16'(m_rt);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        idle_cycle();
        total++;
        if (vld !== 1'b0 || ptch !== held_ptch || ptch_rt !== held_rt) begin
          bad++; $display("FAIL rnd_idle[%0d]: got vld=%b ptch=%h rt=%h want 0 %h %h", i, vld, ptch, ptch_rt, held_ptch, held_rt);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int i = 0; i < SETTLE + 10; i++) apply_sample(16'h0A50, 16'h30A0);
    idle_cycle();
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (ptch !== 16'h0000 || ptch_rt !== 16'h0000 || vld !== 1'b0) begin
      bad++; $display("FAIL midrun_clear: got ptch=%h rt=%h vld=%b want 0", ptch, ptch_rt, vld);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 5; i++) begin
      apply_sample(16'h0050, 16'h00A0);
      total++; if (vld !== (i == 5)) begin bad++; $display("FAIL midrun_vld[%0d]: got %b want %b", i, vld, (i == 5)); end
      total++; if (ptch !== exp_ptch()) begin bad++; $display("FAIL midrun_ptch[%0d]: got %h want %h", i, ptch, exp_ptch()); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    smpl_vld    = 1'b0;
    ptch_rt_raw = 16'h0000;
    AZ          = 16'h0000;
    model_reset();
    test_reset();
    test_settle();
    test_rate();
    test_fusion();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
